// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants and helpers for the channel mux
package mux_pkg;

    localparam logic MODE_EXPLICIT = 1'b0;
    localparam logic MODE_RR       = 1'b1;

    // Index width for a channel count; never narrower than one bit.
    function automatic int sel_width(input int channels);
        return (channels <= 2) ? 1 : $clog2(channels);
    endfunction

    // Low bit of element idx inside a flattened bus of width-bit elements.
    function automatic int slice_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational wrap-around priority search starting at ptr
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int CHANNELS = 8,
    localparam int SEL_W    = sel_width(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    ptr,
    input  logic                enable,
    output logic                grant_valid,
    output logic [SEL_W-1:0]    grant_idx
);

    int cand;

    // First requesting channel at or after ptr, wrapping past CHANNELS-1 to 0.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int i = 0; i < CHANNELS; i++) begin
            cand = int'(ptr) + i;
            if (cand >= CHANNELS) begin
                cand = cand - CHANNELS;
            end
            if (enable && !grant_valid && req[cand[SEL_W-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand[SEL_W-1:0];
            end
        end
    end

endmodule

// File: rtl/chan_mux_rr.sv
// rtl/chan_mux_rr.sv - N:1 stream mux, explicit or round-robin select, registered output (optional CHAN_MUX_XFER_CNT_EN adds xfer_count)
module chan_mux_rr
    import mux_pkg::*;
#(
    parameter  int WIDTH    = 16,
    parameter  int CHANNELS = 8,
    localparam int SEL_W    = sel_width(CHANNELS)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          select,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
`ifdef CHAN_MUX_XFER_CNT_EN
    ,
    output logic [15:0]               xfer_count
`endif
);

    logic             rr_valid;
    logic [SEL_W-1:0] rr_idx;
    logic             sel_ok;
    logic             grant_valid;
    logic [SEL_W-1:0] grant_idx;
    logic             can_load;
    logic             accept;
    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] ptr_next;

    rr_arbiter #(
        .CHANNELS(CHANNELS)
    ) u_arb (
        .req        (in_valid),
        .ptr        (rr_ptr),
        .enable     (mode == MODE_RR),
        .grant_valid(rr_valid),
        .grant_idx  (rr_idx)
    );

    // Grant selection; an out-of-range explicit select never grants.
    always_comb begin
        sel_ok      = (int'(select) < CHANNELS) && in_valid[select];
        grant_valid = (mode == MODE_RR) ? rr_valid : sel_ok;
        grant_idx   = (mode == MODE_RR) ? rr_idx : select;
        can_load    = !out_valid || out_ready;
        accept      = can_load && grant_valid && !reset;
        ptr_next    = (int'(grant_idx) == CHANNELS - 1) ? '0 : grant_idx + 1'b1;
    end

    // One-hot ready toward the granted channel only when the register can take it.
    always_comb begin
        in_ready = '0;
        if (accept) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    // Output register: load on grant, drain to empty otherwise, hold while stalled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            rr_ptr    <= '0;
        end else if (can_load) begin
            out_valid <= grant_valid;
            if (grant_valid) begin
                out_data <= in_data[slice_lsb(int'(grant_idx), WIDTH) +: WIDTH];
                out_chan <= grant_idx;
                if (mode == MODE_RR) begin
                    rr_ptr <= ptr_next;
                end
            end
        end
    end

`ifdef CHAN_MUX_XFER_CNT_EN
    // Saturating count of accepted input transfers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            xfer_count <= 16'd0;
        end else if (accept && (xfer_count != 16'hFFFF)) begin
            xfer_count <= xfer_count + 16'd1;
        end
    end
`endif

endmodule
